relu_backward_mask_fifo: RTL and testbench
==========================================

Name: relu_backward_mask_fifo

Overview:
- Backward (gradient) counterpart of the streaming ReLU activation block.
- Taps the forward activation input stream and records one mask bit per element: 1 when the element is strictly positive.
- On the backward pass, replays the stored mask in the same order against incoming upstream gradients and emits grad_in = mask ? grad : 0.
- Sits beside the forward ReLU in the layer datapath; the mask buffer replaces storage of full 32-bit activations.

Parameters:
- DATA_WIDTH, 32, width of activation and gradient words; bit DATA_WIDTH-1 is the sign bit.
- DEPTH, 64, mask buffer capacity in elements; must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of mask buffer and output stage.
- fwd_valid  in  1  forward activation element valid.
- fwd_data  in  DATA_WIDTH  forward activation element (ReLU input x).
- fwd_ready  out  1  mask buffer can accept an element.
- grad_valid  in  1  upstream gradient valid.
- grad_data  in  DATA_WIDTH  upstream gradient dL/dy.
- grad_ready  out  1  gradient accepted this cycle.
- gin_valid  out  1  output gradient valid.
- gin_data  out  DATA_WIDTH  output gradient dL/dx.
- gin_ready  in  1  downstream accepts gin_data.
- mask_count  out  ADDR_W+1  number of stored, unconsumed mask bits.

Behaviour:
- Reset (rst_n=0 at a clk edge): wr_ptr=0, rd_ptr=0, mask_count=0, gin_valid=0, gin_data=0. fwd_ready and grad_ready are held 0 while rst_n=0. Mask storage contents are don't-care.
- Mask rule: bit = (fwd_data[DATA_WIDTH-1]==0) && (fwd_data[DATA_WIDTH-2:0]!=0). +0 and -0 both give 0, all negatives give 0.
- Push:
  - fwd_ready = !flush && (mask_count != DEPTH).
  - Push occurs when fwd_valid && fwd_ready: mask[wr_ptr] <= bit; wr_ptr increments and wraps from DEPTH-1 to 0.
- Pop/compute:
  - grad_ready = !flush && (mask_count != 0) && (!gin_valid || gin_ready).
  - On grad_valid && grad_ready: gin_data <= mask[rd_ptr] ? grad_data : 0; gin_valid <= 1; rd_ptr increments and wraps.
  - Latency is exactly 1 cycle from grad handshake to gin_valid.
  - Throughput is 1 element/cycle while gin_ready=1.
- Output stage:
  - If gin_valid && !gin_ready, gin_data and gin_valid hold stable.
  - If gin_valid && gin_ready and no new pop, gin_valid <= 0; gin_data holds its last value.
- Counting:
  - mask_count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Full/empty decisions use the registered mask_count. No same-cycle bypass: a pop cannot consume a bit pushed in the same cycle, and a push at full is refused even if a pop occurs that cycle.
- Wrap-around: pointers wrap independently. Order is strictly FIFO across wrap.
- flush:
  - Highest priority after reset; no push or pop occurs in a flush cycle.
  - Next cycle: pointers=0, mask_count=0, gin_valid=0, gin_data=0.
  - Any held gin element is discarded.
- Reset mid-operation: same effect as flush plus ready outputs low during reset. Stored mask bits are lost.
- Gradient values are passed bit-exact (no float arithmetic). A zero result is all-zero bits (+0).

Test Plan:
- Basic: push x = 0x3F800000, 0xBF800000, 0x00000000, 0x80000000, 0x00000001. Then send grad 0x40000000 x5 with gin_ready=1 -> gin_data = 0x40000000, 0, 0, 0, 0x40000000, each exactly 1 cycle after its handshake. mask_count goes 5 -> 0.
- Full/empty:
  - Push 64 positives with no grads -> fwd_ready=0 at mask_count=64, and the 65th fwd_valid is not accepted.
  - With mask_count=0, grad_valid=1 -> grad_ready=0 and gin_valid stays 0.
- Wrap and concurrency: stream 200 elements with alternating sign, fwd_valid and grad_valid both held 1 (grads lagging by 3) -> gin_data alternates grad/0 in order across pointer wrap, mask_count stays 3 in steady state, and no element is dropped or duplicated.
- Backpressure: hold gin_ready=0 for 4 cycles with a valid output -> gin_data stable, grad_ready=0, mask_count unchanged. Release -> the next pop occurs that same cycle, so a back-to-back output follows.
- Flush/reset mid-stream: with mask_count=10 and gin_valid=1, assert flush for 1 cycle -> next cycle mask_count=0, gin_valid=0. A new push/pop sequence then starts from pointer 0 with correct results. Repeat with rst_n=0 -> same outcome, with both ready outputs 0 during reset.

Source files
------------

// File: rtl/relu_backward_mask_fifo_if.sv
// Handshake bundle for the ReLU backward mask FIFO: forward activation tap,
// upstream gradient input, output gradient stream and the occupancy count.
interface relu_backward_mask_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  fwd_valid;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_ready;

    logic                  grad_valid;
    logic [DATA_WIDTH-1:0] grad_data;
    logic                  grad_ready;

    logic                  gin_valid;
    logic [DATA_WIDTH-1:0] gin_data;
    logic                  gin_ready;

    logic [ADDR_W:0]       mask_count;

    // Producer/consumer side (layer datapath or testbench)
    modport master (
        output fwd_valid, fwd_data, grad_valid, grad_data, gin_ready,
        input  fwd_ready, grad_ready, gin_valid, gin_data, mask_count
    );

    // Mask FIFO side
    modport slave (
        input  fwd_valid, fwd_data, grad_valid, grad_data, gin_ready,
        output fwd_ready, grad_ready, gin_valid, gin_data, mask_count
    );
endinterface

// File: rtl/relu_backward_mask_fifo.sv
// ReLU backward pass: stores one "x > 0" bit per forward activation in a
// circular buffer and replays the bits in order to gate upstream gradients.
// The output is a single registered stage with valid/ready backpressure.
module relu_backward_mask_fifo #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 64,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    relu_backward_mask_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0]      mask_mem;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [ADDR_W:0]       count_q;
    logic                  gin_valid_q;
    logic [DATA_WIDTH-1:0] gin_data_q;

    logic mask_bit;
    logic push;
    logic pop;

    // Readiness comes only from registered state, so a bit pushed this cycle
    // is never popped in the same cycle and a full buffer refuses pushes
    // even when a pop is happening.
    assign mask_bit       = !bus.fwd_data[DATA_WIDTH-1] &&
                            (bus.fwd_data[DATA_WIDTH-2:0] != '0);
    assign bus.fwd_ready  = rst_n && !flush && (count_q != COUNT_FULL);
    assign bus.grad_ready = rst_n && !flush && (count_q != '0) &&
                            (!gin_valid_q || bus.gin_ready);
    assign push           = bus.fwd_valid  && bus.fwd_ready;
    assign pop            = bus.grad_valid && bus.grad_ready;

    assign bus.gin_valid  = gin_valid_q;
    assign bus.gin_data   = gin_data_q;
    assign bus.mask_count = count_q;

    // Mask storage has no reset; stale bits are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= mask_bit;
        end
    end

    // Pointers, occupancy and output stage; reset and flush both return
    // the block to an empty state and drop any held output.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            gin_valid_q <= 1'b0;
            gin_data_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pop) begin
                gin_valid_q <= 1'b1;
                gin_data_q  <= mask_mem[rd_ptr] ? bus.grad_data : '0;
            end else if (gin_valid_q && bus.gin_ready) begin
                gin_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_relu_backward_mask_fifo.sv
// Self-checking bench for relu_backward_mask_fifo: a queue-based reference
// model is updated every cycle and compared against all DUT outputs, with
// directed scenarios adding explicit checks on top.
module tb_relu_backward_mask_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: stored mask bits in order, output register
    bit            mq[$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic [DW-1:0] obs_q[$];

    relu_backward_mask_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();

    relu_backward_mask_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs,
                               input logic [DW-1:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge
    task automatic applyStimulus(input logic fv, input logic [DW-1:0] fd,
                                 input logic gv, input logic [DW-1:0] gd,
                                 input logic gr, input logic fl = 1'b0,
                                 input logic rn = 1'b1);
        @(posedge clk);
        #1;
        bus.fwd_valid  = fv;
        bus.fwd_data   = fd;
        bus.grad_valid = gv;
        bus.grad_data  = gd;
        bus.gin_ready  = gr;
        flush          = fl;
        rst_n          = rn;
    endtask

    function automatic bit isPositive(input logic [DW-1:0] x);
        return $signed(x) > 0;
    endfunction

    function automatic logic [DW-1:0] randPositive();
        logic [DW-1:0] v;
        v = $urandom;
        v[DW-1] = 1'b0;
        v[0] = 1'b1;
        return v;
    endfunction

    // Reference model: compares every output on the falling edge, then
    // advances the model by what the coming rising edge will do.
    always @(negedge clk) begin
        bit efr;
        bit egr;
        bit b;
        efr = rst_n && !flush && (mq.size() != DEPTH);
        egr = rst_n && !flush && (mq.size() != 0) && (!m_valid || bus.gin_ready);
        checkOutput("fwd_ready",  32'(bus.fwd_ready),  32'(efr));
        checkOutput("grad_ready", 32'(bus.grad_ready), 32'(egr));
        checkOutput("gin_valid",  32'(bus.gin_valid),  32'(m_valid));
        checkOutput("gin_data",   bus.gin_data,        m_data);
        checkOutput("mask_count", 32'(bus.mask_count), 32'(mq.size()));
        if (bus.gin_valid && bus.gin_ready) obs_q.push_back(bus.gin_data);
        if (!rst_n || flush) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = '0;
        end else begin
            if (bus.grad_valid && egr) begin
                b = mq.pop_front();
                m_data  = b ? bus.grad_data : '0;
                m_valid = 1'b1;
            end else if (m_valid && bus.gin_ready) begin
                m_valid = 1'b0;
            end
            if (bus.fwd_valid && efr) mq.push_back(isPositive(bus.fwd_data));
        end
    end

    // Directed sequence: five signed-zero/sign cases against a fixed gradient
    task automatic runBasic(input string tag);
        logic [DW-1:0] xs [5];
        logic [DW-1:0] exp [5];
        xs  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000, 32'h00000001};
        exp = '{32'h40000000, 32'h0, 32'h0, 32'h0, 32'h40000000};
        obs_q.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, xs[i], 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        checkOutput({tag, "_count5"}, 32'(bus.mask_count), 32'd5);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 32'h40000000, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        checkOutput({tag, "_count0"}, 32'(bus.mask_count), 32'd0);
        checkOutput({tag, "_nout"}, 32'(obs_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++)
            checkOutput({tag, "_data"}, obs_q[i], exp[i]);
    endtask

    // Bring occupancy to 10 with one output held, ready for flush/reset
    task automatic loadTen();
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, randPositive(), 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h12345678, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk); #1;
        checkOutput("load_count10", 32'(bus.mask_count), 32'd10);
        checkOutput("load_gin_valid", 32'(bus.gin_valid), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] specials [6];
        specials = '{32'h0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF,
                     32'h7FFFFFFF, 32'h80000001};
        bus.fwd_valid  = 1'b0;
        bus.fwd_data   = '0;
        bus.grad_valid = 1'b0;
        bus.grad_data  = '0;
        bus.gin_ready  = 1'b0;

        // Reset state
        applyStimulus(1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("rst_count", 32'(bus.mask_count), 32'd0);
        checkOutput("rst_gin_valid", 32'(bus.gin_valid), 32'd0);
        checkOutput("rst_fwd_ready", 32'(bus.fwd_ready), 32'd0);
        checkOutput("rst_grad_ready", 32'(bus.grad_ready), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        $display("[TB] basic mask/gradient sequence");
        runBasic("basic");

        $display("[TB] full and empty boundaries");
        obs_q.delete();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, randPositive(), 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h00000005, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        checkOutput("full_count", 32'(bus.mask_count), 32'(DEPTH));
        checkOutput("full_fwd_ready", 32'(bus.fwd_ready), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        checkOutput("full_no_65th", 32'(bus.mask_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, '0, 1'b1, $urandom | 32'h1, 1'b1);
        @(negedge clk); #1;
        checkOutput("empty_count", 32'(bus.mask_count), 32'd0);
        checkOutput("empty_grad_ready", 32'(bus.grad_ready), 32'd0);
        checkOutput("full_drain_n", 32'(obs_q.size()), 32'(DEPTH));
        applyStimulus(1'b0, '0, 1'b1, 32'hAAAA5555, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 32'hAAAA5555, 1'b1);
        @(negedge clk); #1;
        checkOutput("empty_gin_valid", 32'(bus.gin_valid), 32'd0);

        $display("[TB] wrap and concurrency");
        obs_q.delete();
        for (int i = 0; i < 206; i++) begin
            applyStimulus(i < 200, (i % 2 == 0) ? randPositive() : ($urandom | 32'h80000000),
                          (i >= 3) && (i < 203), $urandom | 32'h1, 1'b1);
            if (i == 50 || i == 120 || i == 199) begin
                @(negedge clk); #1;
                checkOutput("wrap_count3", 32'(bus.mask_count), 32'd3);
            end
        end
        checkOutput("wrap_n", 32'(obs_q.size()), 32'd200);
        for (int k = 0; k < obs_q.size(); k++)
            checkOutput("wrap_order", 32'(obs_q[k] != '0), 32'(k % 2 == 0));

        $display("[TB] output backpressure");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, randPositive(), 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 32'h0BADBEEF, 1'b0);
        @(negedge clk); #1;
        held = bus.gin_data;
        checkOutput("bp_first", held, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 32'h0BADBEEF, 1'b0);
            @(negedge clk); #1;
            checkOutput("bp_hold_data", bus.gin_data, held);
            checkOutput("bp_grad_ready", 32'(bus.grad_ready), 32'd0);
            checkOutput("bp_count", 32'(bus.mask_count), 32'd5);
        end
        applyStimulus(1'b0, '0, 1'b1, 32'h0BADBEEF, 1'b1);
        @(negedge clk); #1;
        checkOutput("bp_release_ready", 32'(bus.grad_ready), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 32'h0BADBEEF, 1'b1);
        @(negedge clk); #1;
        checkOutput("bp_b2b_data", bus.gin_data, 32'h0BADBEEF);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, $urandom, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        $display("[TB] flush mid-stream");
        loadTen();
        applyStimulus(1'b1, randPositive(), 1'b1, 32'h1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        checkOutput("flush_count", 32'(bus.mask_count), 32'd0);
        checkOutput("flush_gin_valid", 32'(bus.gin_valid), 32'd0);
        checkOutput("flush_gin_data", bus.gin_data, 32'd0);
        runBasic("post_flush");

        $display("[TB] reset mid-stream");
        loadTen();
        applyStimulus(1'b1, randPositive(), 1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("rstm_fwd_ready", 32'(bus.fwd_ready), 32'd0);
        checkOutput("rstm_grad_ready", 32'(bus.grad_ready), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk); #1;
        checkOutput("rstm_count", 32'(bus.mask_count), 32'd0);
        checkOutput("rstm_gin_valid", 32'(bus.gin_valid), 32'd0);
        runBasic("post_reset");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 5)] : $urandom,
                          $urandom_range(0, 2) != 0, $urandom,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 49) == 0,
                          $urandom_range(0, 99) != 0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
